// File: rtl/video_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
// Shared types for the raster timing generator.
//   VT_CW              default width of timing inputs, counters and coordinates
//   VT_CW_MAX          widest CW the shared structs can carry
//   axis_timing_t      raw per-axis timing (active, fp, sync, bp, total)
//   axis_bounds_t      per-axis region bounds, one bit wider than a timing field
//   vt_region_e        raster region of one axis
// ---------------------------------------------------------------------------
package video_timing_pkg;

  localparam int VT_CW     = 12;
  localparam int VT_CW_MAX = 16;

  // Fields are VT_CW_MAX wide so one struct type serves any CW <= VT_CW_MAX;
  // narrower timing values are zero-extended into it.
  typedef struct packed {
    logic [VT_CW_MAX-1:0] active;
    logic [VT_CW_MAX-1:0] fp;
    logic [VT_CW_MAX-1:0] sync;
    logic [VT_CW_MAX-1:0] bp;
    logic [VT_CW_MAX-1:0] total;
  } axis_timing_t;

  typedef struct packed {
    logic [VT_CW_MAX:0] act_end;     // first non-active count
    logic [VT_CW_MAX:0] sync_start;  // first sync count
    logic [VT_CW_MAX:0] sync_end;    // first count after sync
    logic [VT_CW_MAX:0] last;        // total - 1
  } axis_bounds_t;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } vt_region_e;

endpackage

// File: rtl/video_timing_gen_timing_axis.sv
// ---------------------------------------------------------------------------
// timing_axis
// One raster axis: shadowed region bounds, a position counter and the region
// decode of that counter.
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture bounds and consistency flag from 'timing'
//   run          count when high; counter forced to 0 when low
//   advance      step the counter this cycle
//   timing       live timing fields for this axis
//   cnt          current position, 0..total-1
//   region       decoded region of cnt
//   wrap         advance on the last position (counter returns to 0)
//   err          shadowed timing is inconsistent (reset value 1)
// ---------------------------------------------------------------------------
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int CW        = VT_CW,
  parameter int MIN_TOTAL = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          run,
  input  logic          advance,
  input  axis_timing_t  timing,
  output logic [CW-1:0] cnt,
  output vt_region_e    region,
  output logic          wrap,
  output logic          err
);

  localparam int BW = VT_CW_MAX + 1;  // bound width
  localparam int SW = VT_CW_MAX + 2;  // four-term sum never overflows here

  logic [SW-1:0] act_end_w;
  logic [SW-1:0] sync_start_w;
  logic [SW-1:0] sync_end_w;
  logic [SW-1:0] used_w;
  logic [SW-1:0] total_w;
  logic          err_next;
  axis_bounds_t  bnd;
  logic [BW-1:0] cnt_w;
  logic          at_last;

  always_comb begin
    act_end_w    = SW'(timing.active);
    sync_start_w = act_end_w + SW'(timing.fp);
    sync_end_w   = sync_start_w + SW'(timing.sync);
    used_w       = sync_end_w + SW'(timing.bp);
    total_w      = SW'(timing.total);
    err_next     = (used_w > total_w) || (total_w < SW'(MIN_TOTAL));
  end

  // Bounds are the shadow: they change only when load is high. When the
  // timing is consistent every bound fits in BW bits; when it is not, the
  // bounds are never used because err holds the counters at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bnd <= '0;
      err <= 1'b1;
    end else if (load) begin
      bnd.act_end    <= BW'(act_end_w);
      bnd.sync_start <= BW'(sync_start_w);
      bnd.sync_end   <= BW'(sync_end_w);
      bnd.last       <= BW'(total_w - SW'(1));
      err            <= err_next;
    end
  end

  assign cnt_w   = BW'(cnt);
  assign at_last = (cnt_w == bnd.last);
  assign wrap    = advance & at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= at_last ? '0 : cnt + 1'b1;
    end
  end

  // Zero-length fields collapse their region: equal bounds skip it entirely,
  // so a zero sync length never decodes SYNC. Excess total lands in BACK.
  always_comb begin
    if (cnt_w < bnd.act_end) begin
      region = ACTIVE;
    end else if (cnt_w < bnd.sync_start) begin
      region = FRONT;
    end else if (cnt_w < bnd.sync_end) begin
      region = SYNC;
    end else begin
      region = BACK;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
// Programmable raster timing generator (pixel_clock domain).
//   pixel_clock, reset_n        clock, asynchronous active-low reset
//   enable                      run when high; counters 0, outputs idle when low
//   h_* / v_* timing            active, front porch, sync, back porch, total
//   h_sync_pol, v_sync_pol      1 = active-high sync pulse
//   h_sync, v_sync              syncs with polarity applied
//   data_enable, x, y           active flag and coordinates (0 outside active)
//   line_start, frame_start     one-cycle strobes at line / frame origin
//   config_error                shadowed timing inconsistent
// Counter-to-pin latency is 1 + DE_DELAY cycles (DE_DELAY in 0..3); every
// output passes through the same pipeline so they stay aligned.
// ---------------------------------------------------------------------------
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CW       = VT_CW,
  parameter int DE_DELAY = 0
) (
  input  logic          pixel_clock,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [CW-1:0] h_active,
  input  logic [CW-1:0] h_front_porch,
  input  logic [CW-1:0] h_sync_length,
  input  logic [CW-1:0] h_back_porch,
  input  logic [CW-1:0] h_total,
  input  logic [CW-1:0] v_active,
  input  logic [CW-1:0] v_front_porch,
  input  logic [CW-1:0] v_sync_length,
  input  logic [CW-1:0] v_back_porch,
  input  logic [CW-1:0] v_total,
  input  logic          h_sync_pol,
  input  logic          v_sync_pol,
  output logic          h_sync,
  output logic          v_sync,
  output logic          data_enable,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          config_error
);

  typedef struct packed {
    logic          de;
    logic          hs;   // sync pulse asserted, before polarity
    logic          vs;
    logic          ls;
    logic          fs;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } out_stage_t;

  axis_timing_t  h_timing;
  axis_timing_t  v_timing;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  vt_region_e    h_region;
  vt_region_e    v_region;
  logic          h_wrap;
  logic          v_wrap;
  logic          h_err;
  logic          v_err;
  logic          run;
  logic          load;
  out_stage_t    stage0;
  out_stage_t    pipe [DE_DELAY+1];
  out_stage_t    last_stage;

  assign h_timing = '{active: VT_CW_MAX'(h_active), fp: VT_CW_MAX'(h_front_porch),
                      sync: VT_CW_MAX'(h_sync_length), bp: VT_CW_MAX'(h_back_porch),
                      total: VT_CW_MAX'(h_total)};
  assign v_timing = '{active: VT_CW_MAX'(v_active), fp: VT_CW_MAX'(v_front_porch),
                      sync: VT_CW_MAX'(v_sync_length), bp: VT_CW_MAX'(v_back_porch),
                      total: VT_CW_MAX'(v_total)};

  assign config_error = h_err | v_err;
  assign run          = enable & ~config_error;
  // v_wrap is exactly the last cycle of the frame. While idle or inconsistent
  // the shadow follows the inputs every cycle; after reset config_error is 1,
  // so the first edge after reset release loads the shadow.
  assign load         = ~enable | config_error | (run & v_wrap);

  timing_axis #(.CW(CW), .MIN_TOTAL(2)) u_h_axis (
    .clk     (pixel_clock),
    .rst_n   (reset_n),
    .load    (load),
    .run     (run),
    .advance (1'b1),
    .timing  (h_timing),
    .cnt     (h_cnt),
    .region  (h_region),
    .wrap    (h_wrap),
    .err     (h_err)
  );

  timing_axis #(.CW(CW), .MIN_TOTAL(1)) u_v_axis (
    .clk     (pixel_clock),
    .rst_n   (reset_n),
    .load    (load),
    .run     (run),
    .advance (h_wrap),
    .timing  (v_timing),
    .cnt     (v_cnt),
    .region  (v_region),
    .wrap    (v_wrap),
    .err     (v_err)
  );

  always_comb begin
    stage0 = '0;
    if (run) begin
      stage0.de = (h_region == ACTIVE) && (v_region == ACTIVE);
      stage0.hs = (h_region == SYNC);
      stage0.vs = (v_region == SYNC);
      stage0.ls = (h_cnt == '0);
      stage0.fs = (h_cnt == '0) && (v_cnt == '0);
      if ((h_region == ACTIVE) && (v_region == ACTIVE)) begin
        stage0.x = h_cnt;
        stage0.y = v_cnt;
      end
    end
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= DE_DELAY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= stage0;
      for (int i = 1; i <= DE_DELAY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign last_stage = pipe[DE_DELAY];

  // Polarity is applied after the registers so the reset level of each sync
  // follows the live polarity input (inactive = ~pol).
  assign h_sync      = last_stage.hs ~^ h_sync_pol;
  assign v_sync      = last_stage.vs ~^ v_sync_pol;
  assign data_enable = last_stage.de;
  assign x           = last_stage.x;
  assign y           = last_stage.y;
  assign line_start  = last_stage.ls;
  assign frame_start = last_stage.fs;

endmodule
